load_store_unit: RTL and testbench



---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/lsu_data_align.sv | 80 ++++++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the RV32I load/store unit.
//   - funct3 encodings for loads and stores
//   - lsu_state_t: load/store unit sequencer states
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational byte-lane steering for RV32I sub-word access.
// Ports:
//   we         in   1 = store, 0 = load
//   funct3     in   RV32I funct3 of the access
//   addr_lo    in   byte offset within the word (addr[1:0])
//   wdata      in   store data as presented by the core
//   rword      in   memory word being read
//   byte_en    out  per-byte write enables for a store
//   store_word out  store data replicated/placed into the selected lane(s)
//   load_data  out  selected lane, sign- or zero-extended
//   bad_access out  misaligned address or illegal funct3
module lsu_data_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rword,
  output logic [XLEN/8-1:0] byte_en,
  output logic [XLEN-1:0]   store_word,
  output logic [XLEN-1:0]   load_data,
  output logic              bad_access
);

  localparam int NB = XLEN / 8;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rword[{addr_lo, 3'b000} +: 8];
  assign rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en    = '0;
    store_word = '0;
    load_data  = '0;
    bad_access = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          byte_en    = NB'(1) << addr_lo;
          store_word = {NB{wdata[7:0]}};
        end
        F3_SH: begin
          byte_en    = NB'(3) << {addr_lo[1], 1'b0};
          store_word = {(NB/2){wdata[15:0]}};
          bad_access = addr_lo[0];
        end
        F3_SW: begin
          byte_en    = '1;
          store_word = wdata;
          bad_access = (addr_lo != 2'b00);
        end
        default: bad_access = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  load_data = {{(XLEN-8){rd_byte[7]}}, rd_byte};
        F3_LBU: load_data = {{(XLEN-8){1'b0}}, rd_byte};
        F3_LH: begin
          load_data  = {{(XLEN-16){rd_half[15]}}, rd_half};
          bad_access = addr_lo[0];
        end
        F3_LHU: begin
          load_data  = {{(XLEN-16){1'b0}}, rd_half};
          bad_access = addr_lo[0];
        end
        F3_LW: begin
          load_data  = rword;
          bad_access = (addr_lo != 2'b00);
        end
        default: bad_access = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit with an integrated word-organised
// data memory, configurable wait states and a valid/ready request handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; latches it on req_valid
//   WAIT  | counting down wait states
//   RESP  | one-cycle response strobe; stores commit on the exit edge
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_valid/req_ready  request handshake (accept when both high)
//   req_we, req_funct3, req_addr, req_wdata  request payload
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data (0 for stores and errors)
//   rsp_err       misaligned, out-of-range or illegal funct3
//   busy          request in flight
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  lsu_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // The aligner checks the incoming request while idle and the latched
  // request otherwise, so one instance serves both error detection and data.
  logic            a_we;
  logic [2:0]      a_funct3;
  logic [1:0]      a_addr_lo;
  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] store_word;
  logic [XLEN-1:0] load_data;
  logic            bad_access;
  logic            out_of_range;
  logic            req_err;

  assign a_we      = (state_q == IDLE) ? req_we         : we_q;
  assign a_funct3  = (state_q == IDLE) ? req_funct3     : funct3_q;
  assign a_addr_lo = (state_q == IDLE) ? req_addr[1:0]  : addr_lo_q;

  lsu_data_align #(.XLEN(XLEN)) u_align (
    .we         (a_we),
    .funct3     (a_funct3),
    .addr_lo    (a_addr_lo),
    .wdata      (wdata_q),
    .rword      (mem[idx_q]),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .bad_access (bad_access)
  );

  assign out_of_range = |req_addr[XLEN-1:AW+2];
  assign req_err      = bad_access | out_of_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err || LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        addr_lo_q <= req_addr[1:0];
        idx_q     <= req_addr[AW+1:2];
        wdata_q   <= req_wdata;
        err_q     <= req_err;
      end
    end
  end

  // Memory is not reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && we_q && !err_q) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[idx_q][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = (state_q == RESP && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: three units (LATENCY 1, 0, 3) driven by directed
// requests; expected responses go to a scoreboard queue that a negedge
// monitor drains whenever a unit strobes rsp_valid.
module tb_load_store_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];
  logic        busy       [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    load_store_unit #(
      .XLEN(32), .DEPTH_WORDS(64),
      .LATENCY((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .busy       (busy[g])
    );
  end

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        if (sb.size() == 0 || sb[0].dut != d) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 want no response", d);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata[d], e.rdata);
          check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Drives one request at a negedge, waits for acceptance, queues the
  // expected response and returns at the negedge right after acceptance.
  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit chk);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout dut%0d: got req_ready=0 want 1", d);
    end
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    @(posedge clk);
    #1;
    if (chk) begin
      e.dut   = d;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + (exp_err ? 0 : lat_of(d));
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic xfer(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    issue(d, we, f3, addr, wd, exp_rd, exp_err, 1'b1);
    wait_done();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_funct3[d] = 3'd0;
      req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_req_ready", {31'b0, req_ready[d]}, 32'd1);
      check("reset_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      check("reset_rsp_err",   {31'b0, rsp_err[d]}, 32'd0);
      check("reset_busy",      {31'b0, busy[d]}, 32'd0);
    end

    // LATENCY=1: word and sub-word access
    xfer(0, 1'b1, F3_SW,  32'h10, 32'hABCDEF11, 32'h0,        1'b0);
    xfer(0, 1'b0, F3_LW,  32'h10, 32'h0,        32'hABCDEF11, 1'b0);
    xfer(0, 1'b0, F3_LB,  32'h11, 32'h0,        32'hFFFFFFEF, 1'b0);
    xfer(0, 1'b0, F3_LBU, 32'h11, 32'h0,        32'h000000EF, 1'b0);
    xfer(0, 1'b0, F3_LH,  32'h12, 32'h0,        32'hFFFFABCD, 1'b0);
    xfer(0, 1'b0, F3_LHU, 32'h12, 32'h0,        32'h0000ABCD, 1'b0);
    xfer(0, 1'b1, F3_SB,  32'h13, 32'h00000012, 32'h0,        1'b0);
    xfer(0, 1'b0, F3_LW,  32'h10, 32'h0,        32'h12CDEF11, 1'b0);
    xfer(0, 1'b1, F3_SH,  32'h10, 32'h5555BEEF, 32'h0,        1'b0);
    xfer(0, 1'b0, F3_LW,  32'h10, 32'h0,        32'h12CDBEEF, 1'b0);
    xfer(0, 1'b0, F3_LB,  32'h13, 32'h0,        32'h00000012, 1'b0);
    xfer(0, 1'b0, F3_LH,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);

    // error responses: no write, zero data, no wait states
    xfer(0, 1'b0, F3_LW,  32'h12,  32'h0,        32'h0, 1'b1);
    xfer(0, 1'b1, F3_SH,  32'h11,  32'h0000FFFF, 32'h0, 1'b1);
    xfer(0, 1'b0, F3_LW,  32'h100, 32'h0,        32'h0, 1'b1);
    xfer(0, 1'b0, 3'd3,   32'h10,  32'h0,        32'h0, 1'b1);
    xfer(0, 1'b1, 3'd4,   32'h10,  32'hFFFFFFFF, 32'h0, 1'b1);
    xfer(0, 1'b1, F3_SW,  32'h12,  32'hFFFFFFFF, 32'h0, 1'b1);
    xfer(0, 1'b0, F3_LW,  32'h10,  32'h0,        32'h12CDBEEF, 1'b0);

    // LATENCY=0
    xfer(1, 1'b1, F3_SW, 32'h0, 32'h80000001, 32'h0, 1'b0);
    issue(1, 1'b0, F3_LW, 32'h0, 32'h0, 32'h80000001, 1'b0, 1'b1);
    check("lat0_ready_in_resp", {31'b0, req_ready[1]}, 32'd0);
    wait_done();
    xfer(1, 1'b0, F3_LH,  32'h2, 32'h0, 32'hFFFF8000, 1'b0);
    xfer(1, 1'b0, F3_LBU, 32'h0, 32'h0, 32'h00000001, 1'b0);

    // LATENCY=3: ready low through WAIT and RESP, pulse during WAIT ignored
    xfer(2, 1'b1, F3_SW, 32'h20, 32'h01234567, 32'h0, 1'b0);
    issue(2, 1'b0, F3_LW, 32'h20, 32'h0, 32'h01234567, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("lat3_ready_low", {31'b0, req_ready[2]}, 32'd0);
      if (i == 1) begin
        req_we[2]     = 1'b1;
        req_funct3[2] = F3_SW;
        req_addr[2]   = 32'h20;
        req_wdata[2]  = 32'hFFFF0000;
        req_valid[2]  = 1'b1;
      end else begin
        req_valid[2]  = 1'b0;
      end
      @(negedge clk);
    end
    wait_done();
    xfer(2, 1'b0, F3_LW, 32'h20, 32'h0, 32'h01234567, 1'b0);

    // reset during WAIT aborts a store
    issue(2, 1'b1, F3_SW, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    check("abort_req_ready", {31'b0, req_ready[2]}, 32'd1);
    check("abort_busy",      {31'b0, busy[2]}, 32'd0);
    repeat (6) @(negedge clk);
    xfer(2, 1'b0, F3_LW, 32'h20, 32'h0, 32'h01234567, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
